// File: rtl/uart_rx_char.sv
// 8N1 UART receiver producing the char/en strobe for the terminal display.
// Define UART_RX_PARITY_EN to expect an even-parity bit between D7 and STOP.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | line idle, waiting for rxs low
// START    | half-bit wait, confirm start bit or reject glitch
// DATA     | sample 8 data bits LSB first, one per bit period
// PARITY   | sample even-parity bit (UART_RX_PARITY_EN only)
// STOP     | sample stop bit, emit en or frame_err
// RECOVER  | after a low stop bit, wait for the line to return high

module uart_rx_char #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] char,
    output logic       en,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_M1     = DW'(DIV - 1);
    localparam logic [OW-1:0] OS_M1      = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_HALF_M1 = OW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_RECOVER
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t          state_q, state_d;
    logic            meta_q, rxs_q;
    logic [DW-1:0]   div_q, div_d;
    logic [OW-1:0]   os_q, os_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      char_q, char_d;
    logic            en_q, en_d;
    logic            fe_q, fe_d;
    logic            tick, sample, frame_ok;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= S_IDLE;
            div_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            char_q  <= '0;
            en_q    <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            meta_q  <= rx;
            rxs_q   <= meta_q;
            state_q <= state_d;
            div_q   <= div_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            char_q  <= char_d;
            en_q    <= en_d;
            fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Tick divider is a free-running down-counter; os_q counts ticks down to the sample point.
    always_comb begin
        tick    = (div_q == '0);
        sample  = tick && (os_q == '0);
        div_d   = tick ? DIV_M1 : div_q - DW'(1);
        os_d    = tick ? os_q - OW'(1) : os_q;
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        char_d  = char_q;
        en_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = perr_q;
        frame_ok = rxs_q && !perr_q;
`else
        frame_ok = rxs_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    div_d   = DIV_M1;
                    os_d    = OS_HALF_M1;
                end
            end
            S_START: begin
                if (sample) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        os_d    = OS_M1;
                        bit_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    sh_d  = {rxs_q, sh_q[7:1]};
                    os_d  = OS_M1;
                    bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    par_d = par_q ^ rxs_q;
                    if (bit_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_q == 3'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample) begin
                    perr_d  = par_q ^ rxs_q;
                    os_d    = OS_M1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample) begin
                    if (frame_ok) begin
                        char_d  = sh_q;
                        en_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        // A good stop bit after a parity error needs no recovery wait.
                        state_d = rxs_q ? S_IDLE : S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign char      = char_q;
    assign en        = en_q;
    assign frame_err = fe_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_char.sv
// Self-checking bench for uart_rx_char: directed scenarios plus randomized frames
// checked against a frame-level model. Honours UART_RX_PARITY_EN.

module tb_uart_rx_char;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 25_000;
    localparam int OS     = 16;
    localparam int BIT    = CLK_HZ / BAUD;          // 64 clk per bit
    localparam int TICK   = BIT / OS;
`ifdef UART_RX_PARITY_EN
    localparam int NB     = 11;
`else
    localparam int NB     = 10;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] char_w;
    logic       en, frame_err, busy;

    uart_rx_char #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .char      (char_w),
        .en        (en),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed strobes: kind 1 = en, 2 = frame_err.
    int         ev_kind[$];
    logic [7:0] ev_char[$];
    int         ev_cyc[$];
    int         n_overlap = 0, n_char_bad = 0, n_gap_bad = 0;
    int         last_en = -100000;
    logic [7:0] char_prev = 8'h00;

    always @(negedge clk) begin
        if (!reset_n) begin
            char_prev = char_w;
        end else begin
            if (en && frame_err) n_overlap++;
            if (char_w !== char_prev && !en) n_char_bad++;
            char_prev = char_w;
            if (en) begin
                if (cyc - last_en < BIT) n_gap_bad++;
                last_en = cyc;
                ev_kind.push_back(1);
                ev_char.push_back(char_w);
                ev_cyc.push_back(cyc);
            end
            if (frame_err) begin
                ev_kind.push_back(2);
                ev_char.push_back(char_w);
                ev_cyc.push_back(cyc);
            end
        end
    end

    task automatic pop_event(output int kind, output logic [7:0] ch, output int at);
        int t = 0;
        while (ev_kind.size() == 0 && t < 4 * BIT) begin
            @(posedge clk);
            t++;
        end
        if (ev_kind.size() == 0) begin
            kind = 0; ch = 8'h00; at = 0;
        end else begin
            kind = ev_kind.pop_front();
            ch   = ev_char.pop_front();
            at   = ev_cyc.pop_front();
        end
    endtask

    // Callers are always just past a rising edge; each level lasts n clocks.
    task automatic hold(input logic v, input int n);
        #1 rx = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] fr, input int nb, input int blen, output int t0);
        t0 = 0;
        for (int i = 0; i < nb; i++) begin
            #1;
            if (i == 0) t0 = cyc;
            rx = fr[i];
            repeat (blen) @(posedge clk);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic stop, input logic pflip);
`ifdef UART_RX_PARITY_EN
        return {stop, (^d) ^ pflip, d, 1'b0};
`else
        return {stop ^ pflip, stop, d, 1'b0};   // bit 10 is never transmitted in 8N1
`endif
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic stop, output int t0);
        send_bits(make_frame(d, stop, 1'b0), NB, BIT, t0);
    endtask

    task automatic sample_busy(input string tag, input logic exp);
        @(negedge clk);
        chk(tag, busy, exp);
        @(posedge clk);
    endtask

    int         t0, t1, k0, k1, a0, a1;
    logic [7:0] c0, c1;
    logic [7:0] last_good;

    initial begin
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_char", char_w, 8'h00);
        chk("rst_en", en, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // single byte
        send_byte(8'h41, 1'b1, t0);
        hold(1'b1, BIT);
        pop_event(k0, c0, a0);
        chk("s1_kind", k0, 1);
        chk("s1_char", c0, 8'h41);
        chk("s1_lat", (a0 - t0 >= 9 * BIT + BIT / 4) && (a0 - t0 <= 9 * BIT + 3 * BIT / 4), 1'b1);
        chk("s1_extra", ev_kind.size(), 0);

        // start glitch of 3 ticks
        hold(1'b0, 3 * TICK);
        sample_busy("gl_busy_hi", 1'b1);
        hold(1'b1, 2 * BIT);
        chk("gl_none", ev_kind.size(), 0);
        sample_busy("gl_busy_lo", 1'b0);

        // bad stop bit then break
        send_byte(8'h55, 1'b0, t0);
        hold(1'b0, 20 * BIT);
        pop_event(k0, c0, a0);
        chk("bs_kind", k0, 2);
        chk("bs_char", c0, 8'h41);
        chk("bs_single", ev_kind.size(), 0);
        sample_busy("bs_recover_busy", 1'b1);
        hold(1'b1, 2 * BIT);
        send_byte(8'h0A, 1'b1, t0);
        hold(1'b1, BIT);
        pop_event(k0, c0, a0);
        chk("bs_next_kind", k0, 1);
        chk("bs_next_char", c0, 8'h0A);

        // back-to-back frames
        send_byte(8'h0D, 1'b1, t0);
        send_byte(8'h68, 1'b1, t1);
        hold(1'b1, BIT);
        pop_event(k0, c0, a0);
        pop_event(k1, c1, a1);
        chk("b2b_k0", k0, 1);
        chk("b2b_c0", c0, 8'h0D);
        chk("b2b_k1", k1, 1);
        chk("b2b_c1", c1, 8'h68);
        chk("b2b_gap", (a1 - a0 >= 10 * BIT - TICK) && (a1 - a0 <= 10 * BIT + TICK), 1'b1);

        // reset in the middle of bit 3
        send_bits(make_frame(8'h7E, 1'b1, 1'b0), 4, BIT, t0);
        hold(1'b0 ^ 1'b1, BIT / 2);   // bit 3 of 0x7E is 1
        #1 reset_n = 1'b0;
        #1;
        chk("rm_char", char_w, 8'h00);
        chk("rm_en", en, 1'b0);
        chk("rm_fe", frame_err, 1'b0);
        chk("rm_busy", busy, 1'b0);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        chk("rm_none", ev_kind.size(), 0);
        send_byte(8'h7E, 1'b1, t0);
        hold(1'b1, BIT);
        pop_event(k0, c0, a0);
        chk("rm_kind", k0, 1);
        chk("rm_char2", c0, 8'h7E);
        last_good = 8'h7E;

`ifdef UART_RX_PARITY_EN
        send_bits({1'b1, 1'b0, 8'h41, 1'b0}, 11, BIT, t0);
        hold(1'b1, BIT);
        pop_event(k0, c0, a0);
        chk("par_ok_kind", k0, 1);
        chk("par_ok_char", c0, 8'h41);
        send_bits({1'b1, 1'b1, 8'h41, 1'b0}, 11, BIT, t0);
        hold(1'b1, BIT);
        pop_event(k0, c0, a0);
        chk("par_bad_kind", k0, 2);
        chk("par_bad_char", c0, 8'h41);
        last_good = 8'h41;
`endif

        // randomized frames against the frame-level model
        for (int k = 0; k < 40; k++) begin
            logic [7:0] d;
            logic       stop, pflip, exp_ok;
            int         blen;
            d     = 8'($urandom);
            stop  = ($urandom_range(0, 5) != 0);
            blen  = $urandom_range(BIT - 1, BIT + 1);
`ifdef UART_RX_PARITY_EN
            pflip = ($urandom_range(0, 4) == 0);
`else
            pflip = 1'b0;
`endif
            exp_ok = stop && !pflip;
            send_bits(make_frame(d, stop, pflip), NB, blen, t0);
            if (!stop) begin
                hold(1'b0, $urandom_range(0, BIT));
                hold(1'b1, BIT + $urandom_range(0, 40));
            end else begin
                hold(1'b1, $urandom_range(0, 40));
            end
            pop_event(k0, c0, a0);
            chk("rnd_kind", k0, exp_ok ? 1 : 2);
            chk("rnd_char", c0, exp_ok ? d : last_good);
            if (exp_ok) last_good = d;
        end

        hold(1'b1, 2 * BIT);
        chk("end_no_extra", ev_kind.size(), 0);
        chk("end_overlap", n_overlap, 0);
        chk("end_char_hold", n_char_bad, 0);
        chk("end_en_gap", n_gap_bad, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
